gray_to_binary_tracker: RTL and testbench
=========================================

GRAY_TO_BINARY_TRACKER -- requirements
Module: gray_to_binary_tracker

Interface
REQ-001 SHALL have parameter: WIDTH, 4, code width in bits (legal range 2..16).
REQ-002 SHALL have parameter: WRAPW, 8, width of the wrap counter.
REQ-003 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: gray_in  input  WIDTH  Gray-coded sample.
REQ-006 SHALL have port: in_valid  input  1  gray_in valid.
REQ-007 SHALL have port: in_ready  output  1  block can accept a sample.
REQ-008 SHALL have port: bin_out  output  WIDTH  decoded binary value.
REQ-009 SHALL have port: out_valid  output  1  bin_out and status valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts the output.
REQ-011 SHALL have port: dir  output  1  last movement direction: 1 = up, 0 = down.
REQ-012 SHALL have port: step_err  output  1  sticky flag for an illegal Gray transition.
REQ-013 SHALL have port: locked  output  1  a reference sample is held.
REQ-014 SHALL have port: wrap_cnt  output  WRAPW  signed wrap count, two's complement.
REQ-015 SHALL have port: err_clr  input  1  clears the fault and unlocks the tracker.

Function
REQ-016 SHALL decode combinationally as: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i].
REQ-017 SHALL accept a sample when in_valid && in_ready.
REQ-018 SHALL drive in_ready = !out_valid || out_ready, giving a one-entry output register with no combinational path from in_valid.
REQ-019 SHALL register the decoded value in bin_out and set out_valid on the cycle after acceptance (latency 1).
REQ-020 SHALL clear out_valid after an output handshake when no new sample is accepted in the same cycle.
REQ-021 SHALL hold bin_out and all status outputs stable while out_valid && !out_ready.
REQ-022 SHALL implement FSM states UNLOCKED, TRACK and FAULT.
REQ-023 SHALL, in UNLOCKED, store an accepted sample as the reference (prev), set locked, go to TRACK, and leave dir, wrap_cnt and step_err unchanged.
REQ-024 SHALL, in TRACK, compute delta = (bin_new - prev) mod 2^WIDTH for each accepted sample.
REQ-025 SHALL, for delta = 0, hold dir.
REQ-026 SHALL, for delta = 1, set dir = 1, and increment wrap_cnt when prev is all-ones and bin_new = 0.
REQ-027 SHALL, for delta = 2^WIDTH-1, set dir = 0, and decrement wrap_cnt when prev = 0 and bin_new is all-ones.
REQ-028 SHALL, for any other delta, set step_err, leave dir and wrap_cnt unchanged, and go to FAULT.
REQ-029 SHALL update prev with every accepted sample in TRACK and in FAULT.
REQ-030 SHALL, in FAULT, continue decoding and handshaking, keep step_err = 1, keep locked = 1, and freeze dir and wrap_cnt.
REQ-031 SHALL, on err_clr in any state, clear step_err and locked, zero wrap_cnt and go to UNLOCKED.
REQ-032 SHALL treat a sample accepted in the same cycle as err_clr as the new reference: next state TRACK, locked = 1.
REQ-033 SHALL let wrap_cnt wrap modulo 2^WRAPW with no saturation.

Reset
REQ-034 SHALL, on rst high at a clock edge, set: state UNLOCKED, bin_out 0, out_valid 0, dir 1, step_err 0, locked 0, wrap_cnt 0, prev 0.
REQ-035 SHALL give rst priority over err_clr and over any handshake in the same cycle, and discard an in-flight output when reset is asserted mid-operation.
REQ-036 SHALL drive in_ready = 1 during and after reset.

Structure
REQ-037 SHALL define the FSM state encoding (2-bit typedef) in shared package gray_pkg.
REQ-038 SHALL place the Gray-to-binary function in shared package gray_pkg, for reuse alongside the existing binary-to-Gray converter.
REQ-039 SHALL implement the decode in sub-module gray2bin (purely combinational, parameter WIDTH), instantiated once.

Verification (WIDTH=4)
REQ-040 SHALL cover exhaustive decode: gray 0000..1111 with out_ready=1 -> bin_out equals the inverse binary-to-Gray mapping (e.g. 1000 -> 15, 0111 -> 5), each one cycle after acceptance.
REQ-041 SHALL cover up-wrap: samples for 14, 15, 0 (gray 1001, 1000, 0000) -> dir=1, wrap_cnt=1, step_err=0.
REQ-042 SHALL cover down-wrap: samples for 0, 15 after reference 1 -> dir=0, wrap_cnt=-1 (8'hFF).
REQ-043 SHALL cover an illegal step: 2 then 7 (gray 0011, 0100) -> step_err=1, state FAULT, wrap_cnt frozen; then err_clr together with sample 3 -> step_err=0, locked=1, wrap_cnt=0.
REQ-044 SHALL cover backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, bin_out stable, no sample lost or duplicated after release.
REQ-045 SHALL cover reset mid-stream: rst asserted while out_valid=1 -> next cycle out_valid=0, locked=0, wrap_cnt=0, in_ready=1.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and the tracker FSM state encoding.
// Functions operate on MaxWidth bits; narrower codes are zero-extended.
package gray_pkg;

    localparam int unsigned MaxWidth = 16;

    typedef logic [1:0] state_t;

    localparam state_t StUnlocked = 2'd0;
    localparam state_t StTrack    = 2'd1;
    localparam state_t StFault    = 2'd2;

    function automatic logic [MaxWidth-1:0] bin_to_gray(input logic [MaxWidth-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper gray bits decode to zero, so the low bits hold the narrow result.
    function automatic logic [MaxWidth-1:0] gray_to_bin(input logic [MaxWidth-1:0] g);
        logic [MaxWidth-1:0] b;
        b[MaxWidth-1] = g[MaxWidth-1];
        for (int i = MaxWidth - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Purely combinational Gray-to-binary decoder of parameterised width.
module gray2bin
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    logic [MaxWidth-1:0] bin_full;
    logic                unused_bits;

    assign bin_full    = gray_to_bin(MaxWidth'(gray_i));
    assign bin_o       = bin_full[WIDTH-1:0];
    assign unused_bits = ^bin_full;

endmodule

// File: rtl/gray_to_binary_tracker.sv
// Decodes a Gray-coded position stream, tracks direction and wrap count,
// and flags illegal (non-unit) steps. One-entry registered output stage.
module gray_to_binary_tracker
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WRAPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             dir,
    output logic             step_err,
    output logic             locked,
    output logic [WRAPW-1:0] wrap_cnt,
    input  logic             err_clr
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             out_valid_q, out_valid_d;
    logic             dir_q, dir_d;
    logic             step_err_q, step_err_d;
    logic             locked_q, locked_d;
    logic [WRAPW-1:0] wrap_q, wrap_d;

    logic [WIDTH-1:0] bin_new;
    logic [WIDTH-1:0] delta;
    logic             accept;

    gray2bin #(
        .WIDTH (WIDTH)
    ) u_gray2bin (
        .gray_i (gray_in),
        .bin_o  (bin_new)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign delta    = bin_new - prev_q;

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        prev_d      = prev_q;
        out_valid_d = out_valid_q;
        dir_d       = dir_q;
        step_err_d  = step_err_q;
        locked_d    = locked_q;
        wrap_d      = wrap_q;

        if (accept) begin
            out_valid_d = 1'b1;
            bin_d       = bin_new;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (err_clr) begin
            step_err_d = 1'b0;
            locked_d   = 1'b0;
            wrap_d     = '0;
            state_d    = StUnlocked;
            // A sample arriving with the clear becomes the new reference.
            if (accept) begin
                prev_d   = bin_new;
                locked_d = 1'b1;
                state_d  = StTrack;
            end
        end else if (accept) begin
            prev_d = bin_new;
            case (state_q)
                StUnlocked: begin
                    locked_d = 1'b1;
                    state_d  = StTrack;
                end
                StTrack: begin
                    if (delta == '0) begin
                        dir_d = dir_q;
                    end else if (delta == WIDTH'(1)) begin
                        dir_d = 1'b1;
                        if (prev_q == {WIDTH{1'b1}} && bin_new == '0) begin
                            wrap_d = wrap_q + WRAPW'(1);
                        end
                    end else if (delta == {WIDTH{1'b1}}) begin
                        dir_d = 1'b0;
                        if (prev_q == '0 && bin_new == {WIDTH{1'b1}}) begin
                            wrap_d = wrap_q - WRAPW'(1);
                        end
                    end else begin
                        step_err_d = 1'b1;
                        state_d    = StFault;
                    end
                end
                StFault: begin
                    step_err_d = 1'b1;
                    locked_d   = 1'b1;
                end
                default: begin
                    locked_d = 1'b1;
                    state_d  = StTrack;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StUnlocked;
            bin_q       <= '0;
            prev_q      <= '0;
            out_valid_q <= 1'b0;
            dir_q       <= 1'b1;
            step_err_q  <= 1'b0;
            locked_q    <= 1'b0;
            wrap_q      <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            prev_q      <= prev_d;
            out_valid_q <= out_valid_d;
            dir_q       <= dir_d;
            step_err_q  <= step_err_d;
            locked_q    <= locked_d;
            wrap_q      <= wrap_d;
        end
    end

    assign bin_out   = bin_q;
    assign out_valid = out_valid_q;
    assign dir       = dir_q;
    assign step_err  = step_err_q;
    assign locked    = locked_q;
    assign wrap_cnt  = wrap_q;

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Directed bench for gray_to_binary_tracker (WIDTH=4, WRAPW=8).
module tb_gray_to_binary_tracker;
    import gray_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned WW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  gray_in;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  bin_out;
    logic          out_valid;
    logic          out_ready;
    logic          dir;
    logic          step_err;
    logic          locked;
    logic [WW-1:0] wrap_cnt;
    logic          err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] gray;
        logic [W-1:0] bin;
    } vec_t;

    vec_t vecs [16];

    gray_to_binary_tracker #(
        .WIDTH (W),
        .WRAPW (WW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dir       (dir),
        .step_err  (step_err),
        .locked    (locked),
        .wrap_cnt  (wrap_cnt),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One accepted sample with out_ready high; outputs are observed after the edge.
    task automatic send(input logic [W-1:0] g);
        gray_in   = g;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic clear();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    logic [MaxWidth-1:0] g16;

    initial begin
        vecs[0]  = '{4'b0000, 4'd0};   vecs[1]  = '{4'b0001, 4'd1};
        vecs[2]  = '{4'b0010, 4'd3};   vecs[3]  = '{4'b0011, 4'd2};
        vecs[4]  = '{4'b0100, 4'd7};   vecs[5]  = '{4'b0101, 4'd6};
        vecs[6]  = '{4'b0110, 4'd4};   vecs[7]  = '{4'b0111, 4'd5};
        vecs[8]  = '{4'b1000, 4'd15};  vecs[9]  = '{4'b1001, 4'd14};
        vecs[10] = '{4'b1010, 4'd12};  vecs[11] = '{4'b1011, 4'd13};
        vecs[12] = '{4'b1100, 4'd8};   vecs[13] = '{4'b1101, 4'd9};
        vecs[14] = '{4'b1110, 4'd11};  vecs[15] = '{4'b1111, 4'd10};

        rst = 1'b1; gray_in = '0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        tick();
        check("in_ready_in_reset", in_ready, 1);
        tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_bin_out", bin_out, 0);
        check("rst_dir", dir, 1);
        check("rst_step_err", step_err, 0);
        check("rst_locked", locked, 0);
        check("rst_wrap", wrap_cnt, 0);

        // Exhaustive decode
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].gray);
            check($sformatf("decode_g%0d", i), bin_out, vecs[i].bin);
            check($sformatf("decode_valid%0d", i), out_valid, 1);
        end
        tick();
        check("valid_drops_idle", out_valid, 0);
        clear();
        check("clr_step_err", step_err, 0);
        check("clr_locked", locked, 0);
        check("clr_wrap", wrap_cnt, 0);

        // Up-wrap 14, 15, 0
        send(4'b1001);
        check("up_ref_locked", locked, 1);
        send(4'b1000);
        send(4'b0000);
        check("up_dir", dir, 1);
        check("up_wrap", wrap_cnt, 1);
        check("up_step_err", step_err, 0);

        // Down-wrap: reference 1, then 0, 15
        clear();
        send(4'b0001);
        send(4'b0000);
        check("down_dir_first", dir, 0);
        check("down_wrap_first", wrap_cnt, 0);
        send(4'b1000);
        check("down_dir", dir, 0);
        check("down_wrap", wrap_cnt, 8'hFF);

        // Illegal 15 -> 7 keeps the wrap count
        send(4'b1000);
        send(4'b0100);
        check("illegal_frozen_err", step_err, 1);
        check("illegal_frozen_wrap", wrap_cnt, 8'hFF);

        // Illegal 2 -> 7 after a clear
        clear();
        send(4'b0011);
        send(4'b0100);
        check("illegal_err", step_err, 1);
        check("illegal_wrap", wrap_cnt, 0);
        check("illegal_locked", locked, 1);
        send(4'b1100);
        check("fault_dir_frozen", dir, 0);
        check("fault_decode", bin_out, 8);
        check("fault_err_sticky", step_err, 1);
        err_clr = 1'b1;
        send(4'b0010);
        err_clr = 1'b0;
        check("clr_sample_err", step_err, 0);
        check("clr_sample_locked", locked, 1);
        check("clr_sample_wrap", wrap_cnt, 0);
        check("clr_sample_bin", bin_out, 3);
        send(4'b0110);
        check("after_clr_track_dir", dir, 1);
        check("after_clr_track_err", step_err, 0);

        // Backpressure
        tick();
        gray_in = 4'b0111; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check("bp_ready_empty", in_ready, 1);
        tick();
        check("bp_first_bin", bin_out, 5);
        gray_in = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_in_ready%0d", i), in_ready, 0);
            check($sformatf("bp_bin_stable%0d", i), bin_out, 5);
            check($sformatf("bp_valid%0d", i), out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_second_bin", bin_out, 6);
        check("bp_second_valid", out_valid, 1);
        check("bp_no_err", step_err, 0);
        tick();
        check("bp_drained", out_valid, 0);

        // Walk 7..15,0 to get a nonzero wrap count, then reset with a stalled output
        for (int i = 7; i <= 16; i++) begin
            g16 = bin_to_gray(MaxWidth'(i % 16));
            send(g16[W-1:0]);
        end
        check("walk_wrap", wrap_cnt, 1);
        check("walk_err", step_err, 0);
        out_ready = 1'b0;
        send(4'b0001);
        out_ready = 1'b0;
        check("stall_before_rst", out_valid, 1);
        rst = 1'b1;
        tick();
        check("midrst_valid", out_valid, 0);
        check("midrst_locked", locked, 0);
        check("midrst_wrap", wrap_cnt, 0);
        check("midrst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
